// File: rtl/cordic_vector_if.sv
// Handshake bus for the CORDIC vectoring block: an input vector in, magnitude/phase out.
interface cordic_vector_if #(
    parameter int DWIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] x_in;
    logic signed [DWIDTH-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic        [DWIDTH+1:0] mag;
    logic        [31:0]       phase;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, mag, phase
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, mag, phase
    );
endinterface

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring: rotates (x,y) onto the +x axis, one micro-rotation per
// cycle, yielding the gain-scaled magnitude and atan2 phase (2^32 = full turn).
module cordic_vector #(
    parameter int DWIDTH = 16,
    parameter int ITER   = 16
) (
    input  logic            clk,
    input  logic            rst,
    cordic_vector_if.slave  bus
);
    localparam int WW = DWIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [4:0]           cnt;
    logic signed [WW-1:0] x, y;
    logic signed [31:0]   z;
    logic                 zero_in;
    logic [WW-1:0]        mag_r;
    logic [31:0]          phase_r;
    logic                 out_valid_r;

    function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  atan_lut = 32'h2000_0000;
            5'd1:  atan_lut = 32'h12E4_051D;
            5'd2:  atan_lut = 32'h09FB_385B;
            5'd3:  atan_lut = 32'h0511_11D4;
            5'd4:  atan_lut = 32'h028B_0D43;
            5'd5:  atan_lut = 32'h0145_D7E1;
            5'd6:  atan_lut = 32'h00A2_F61E;
            5'd7:  atan_lut = 32'h0051_7C55;
            5'd8:  atan_lut = 32'h0028_BE53;
            5'd9:  atan_lut = 32'h0014_5F2F;
            5'd10: atan_lut = 32'h000A_2F98;
            5'd11: atan_lut = 32'h0005_17CC;
            5'd12: atan_lut = 32'h0002_8BE6;
            5'd13: atan_lut = 32'h0001_45F3;
            5'd14: atan_lut = 32'h0000_A2FA;
            5'd15: atan_lut = 32'h0000_517D;
            5'd16: atan_lut = 32'h0000_28BE;
            5'd17: atan_lut = 32'h0000_145F;
            5'd18: atan_lut = 32'h0000_0A30;
            5'd19: atan_lut = 32'h0000_0518;
            5'd20: atan_lut = 32'h0000_028C;
            5'd21: atan_lut = 32'h0000_0146;
            5'd22: atan_lut = 32'h0000_00A3;
            5'd23: atan_lut = 32'h0000_0051;
            5'd24: atan_lut = 32'h0000_0029;
            5'd25: atan_lut = 32'h0000_0014;
            5'd26: atan_lut = 32'h0000_000A;
            5'd27: atan_lut = 32'h0000_0005;
            5'd28: atan_lut = 32'h0000_0003;
            5'd29: atan_lut = 32'h0000_0001;
            5'd30: atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    // Pre-rotate left-half-plane inputs by +/-90 deg so the micro-rotations converge.
    logic signed [WW-1:0] xe, ye, x_ld, y_ld;
    logic signed [31:0]   z_ld;
    assign xe = {{2{bus.x_in[DWIDTH-1]}}, bus.x_in};
    assign ye = {{2{bus.y_in[DWIDTH-1]}}, bus.y_in};

    always_comb begin
        x_ld = xe;
        y_ld = ye;
        z_ld = '0;
        if (xe < 0) begin
            if (ye >= 0) begin
                x_ld = ye;
                y_ld = -xe;
                z_ld = 32'sh4000_0000;
            end else begin
                x_ld = -ye;
                y_ld = xe;
                z_ld = 32'shC000_0000;
            end
        end
    end

    logic signed [WW-1:0] xs, ys, x_nx, y_nx;
    logic signed [31:0]   ang, z_nx;
    assign xs  = x >>> cnt;
    assign ys  = y >>> cnt;
    assign ang = atan_lut(cnt);

    always_comb begin
        if (y[WW-1]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - ang;
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + ang;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.mag       = mag_r;
    assign bus.phase     = phase_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            zero_in     <= 1'b0;
            mag_r       <= '0;
            phase_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    x       <= x_ld;
                    y       <= y_ld;
                    z       <= z_ld;
                    zero_in <= (bus.x_in == '0) && (bus.y_in == '0);
                    cnt     <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    x   <= x_nx;
                    y   <= y_nx;
                    z   <= z_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        // A zero vector has no defined angle; report 0/0 rather than the table sum.
                        mag_r       <= zero_in ? '0 : x_nx;
                        phase_r     <= zero_in ? '0 : z_nx;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector.sv
// Directed + random checks of cordic_vector against a real-arithmetic atan2/hypot model.
module tb_cordic_vector;
    localparam int DW = 16;
    localparam int IT = 16;
    localparam real TWO32 = 4294967296.0;
    localparam real PI = 3.14159265358979;

    logic clk, rst;
    int   checks = 0;
    int   failures = 0;
    real  gain;

    cordic_vector_if #(.DWIDTH(DW)) bus ();
    cordic_vector #(.DWIDTH(DW), .ITER(IT)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic check_phase(input string tag, input logic [31:0] obs, input logic [31:0] exp, input longint tol);
        logic signed [31:0] d;
        longint ad;
        d = obs - exp;
        ad = (d < 0) ? -longint'(d) : longint'(d);
        checks++;
        assert ((ad <= tol) === 1'b1) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [31:0] ref_phase(input int xi, input int yi);
        real p;
        longint lp;
        p = $atan2(real'(yi), real'(xi)) * TWO32 / (2.0 * PI);
        if (p < 0.0) p = p + TWO32;
        lp = longint'(p);
        if (lp >= 64'sd4294967296) lp = lp - 64'sd4294967296;
        return 32'(lp);
    endfunction

    function automatic longint ref_mag(input int xi, input int yi);
        return longint'(gain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)));
    endfunction

    // Present one vector, wait (bounded) for the result; lat = -1 on timeout.
    task automatic do_case(input int xi, input int yi, output logic [DW+1:0] m,
                           output logic [31:0] p, output int lat);
        bus.in_valid = 1'b1;
        bus.x_in = 16'(xi);
        bus.y_in = 16'(yi);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) lat = n;
        end
        m = bus.mag;
        p = bus.phase;
    endtask

    task automatic model_case(input string tag, input int xi, input int yi);
        logic [DW+1:0] m;
        logic [31:0] p;
        int lat;
        do_case(xi, yi, m, p, lat);
        check({tag, "_lat"}, lat, IT);
        check_tol({tag, "_mag"}, m, ref_mag(xi, yi), 16);
        check_phase({tag, "_phase"}, p, ref_phase(xi, yi), 64'sd524288);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW+1:0] m;
        logic [31:0] p;
        int lat, xi, yi, seen, bad;

        gain = 1.0;
        for (int i = 0; i < IT; i++) gain = gain * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mag", bus.mag, 0);
        check("rst_phase", bus.phase, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_case(10000, 0, m, p, lat);
        check("px_lat", lat, IT);
        check_tol("px_mag", m, 16468, 8);
        check_phase("px_phase", p, 32'h0000_0000, 64'sd262144);
        @(posedge clk); #1;

        do_case(0, 10000, m, p, lat);
        check("py_lat", lat, IT);
        check_tol("py_mag", m, 16468, 8);
        check_phase("py_phase", p, 32'h4000_0000, 64'sd262144);
        @(posedge clk); #1;

        do_case(-10000, -10000, m, p, lat);
        check("q3_lat", lat, IT);
        check_tol("q3_mag", m, 23289, 8);
        check_phase("q3_phase", p, 32'hA000_0000, 64'sd262144);
        @(posedge clk); #1;

        do_case(-32768, 0, m, p, lat);
        check("nx_lat", lat, IT);
        check_tol("nx_mag", m, 53961, 8);
        check_phase("nx_phase", p, 32'h8000_0000, 64'sd262144);
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) begin
            xi = 0;
            yi = 0;
            for (int t = 0; t < 50 && (xi * xi + yi * yi) < 64000000; t++) begin
                xi = int'($urandom_range(60000)) - 30000;
                yi = int'($urandom_range(60000)) - 30000;
            end
            model_case($sformatf("rnd%0d", k), xi, yi);
        end

        // Reset mid-RUN: the previous result in mag must be cleared and no result emitted.
        bus.in_valid = 1'b1;
        bus.x_in = 16'(5000);
        bus.y_in = 16'(3000);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_mag", bus.mag, 0);
        check("midrst_phase", bus.phase, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        check("midrst_no_result", seen, 0);
        model_case("post_rst", 7000, -4000);

        // Zero vector under backpressure.
        bus.out_ready = 1'b0;
        do_case(0, 0, m, p, lat);
        check("zero_lat", lat, IT);
        check("zero_mag", m, 0);
        check("zero_phase", p, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k % 2 == 1);
            bus.x_in = 16'(1234);
            bus.y_in = 16'(-777);
            @(posedge clk); #1;
            if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0 &&
                  bus.mag === '0 && bus.phase === '0)) bad++;
        end
        check("bp_stable", bad, 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", bus.in_ready, 1);
        check("bp_out_valid_after", bus.out_valid, 0);

        // Reset while holding a result in DONE.
        bus.out_ready = 1'b0;
        do_case(1000, 2000, m, p, lat);
        check("done_lat", lat, IT);
        rst = 1'b1;
        #1;
        check("donerst_out_valid", bus.out_valid, 0);
        check("donerst_mag", bus.mag, 0);
        check("donerst_phase", bus.phase, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_case("final", -20000, 15000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: signed input component width.
REQ-002 SHALL have parameter ITER, default 16: number of micro-rotations, legal range 1..31.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: x_in and y_in are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-007 SHALL have port x_in, input, DWIDTH bits, signed: X component.
REQ-008 SHALL have port y_in, input, DWIDTH bits, signed: Y component.
REQ-009 SHALL have port out_valid, output, 1 bit: mag and phase are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port mag, output, DWIDTH+2 bits, unsigned: magnitude with CORDIC gain applied.
REQ-012 SHALL have port phase, output, 32 bits: atan2(y,x) in two's complement, 2^32 = 360 deg (0x2000_0000 = 45 deg, 0x4000_0000 = 90 deg, 0xC000_0000 = -90 deg).

Function
REQ-013 SHALL implement CORDIC vectoring mode, the inverse of the sin/cos rotation block: drive y to 0 and accumulate the rotation angle.
REQ-014 SHALL be iterative, one micro-rotation per cycle, with an FSM of three states: IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = (state == IDLE) combinationally, and SHALL drive out_valid = (state == DONE) from a register.
REQ-016 Accept: SHALL capture the input on the edge where in_valid && in_ready, go to RUN and set the iteration counter to 0.
REQ-017 Accept, x_in >= 0: SHALL load x = x_in, y = y_in, z = 0.
REQ-018 Accept, x_in < 0 and y_in >= 0: SHALL load x = y_in, y = -x_in, z = 0x4000_0000.
REQ-019 Accept, x_in < 0 and y_in < 0: SHALL load x = -y_in, y = x_in, z = 0xC000_0000.
REQ-020 SHALL hold working x and y as signed DWIDTH+2 bits, so that negating -2^(DWIDTH-1) and gain growth (up to 2.33x) never overflow.
REQ-021 SHALL hold working z as signed 32 bits and SHALL let it wrap modulo 2^32.
REQ-022 RUN, iteration i, when y >= 0: x += y>>>i; y -= x>>>i; z += atan[i], using pre-update x and y on the right-hand side.
REQ-023 RUN, iteration i, when y < 0: x -= y>>>i; y += x>>>i; z -= atan[i].
REQ-024 SHALL use atan[i] = round(atan(2^-i) * 2^32 / 2pi), i = 0..30, with atan[0] = 0x2000_0000 and atan[1] = 0x12E4_051D; this is the same table as the rotation block.
REQ-025 SHALL go to DONE after iteration ITER-1 completes, registering mag = final x (non-negative) and phase = final z.
REQ-026 Latency: out_valid SHALL first be high exactly ITER cycles after the accept edge.
REQ-027 Gain: mag SHALL NOT be gain-compensated, i.e. mag ~= 1.6468 * sqrt(x^2 + y^2) for ITER >= 8.
REQ-028 Zero input: x_in == 0 and y_in == 0 SHALL produce mag = 0 and phase = 0, forced at DONE, with the same latency.
REQ-029 Backpressure: in DONE, mag, phase and out_valid SHALL hold stable until out_ready is high.
REQ-030 On the edge where out_valid && out_ready, the FSM SHALL go to IDLE; a new input can be accepted no earlier than the following edge.
REQ-031 in_valid SHALL be ignored in RUN and DONE; no input is captured and no error is flagged.
REQ-032 Throughput SHALL be at most one result per ITER+1 cycles when out_ready is held high.

Reset
REQ-033 While rst is high, the FSM SHALL be in IDLE, out_valid = 0, mag = 0, phase = 0, and the counter and working x/y/z = 0.
REQ-034 Because in_ready follows state == IDLE, in_ready SHALL be 1 while rst is high.
REQ-035 rst asserted mid-RUN or in DONE SHALL take effect immediately, asynchronously; the in-flight result is discarded and never presented.
REQ-036 After rst deasserts, the first rising edge with in_valid high SHALL be a normal accept.

Verification
REQ-037 Bench SHALL use DWIDTH=16, ITER=16, out_ready=1 and check each case below.
- x_in=10000, y_in=0 -> out_valid exactly 16 cycles after accept; mag=16468 +/-8; phase=0 +/-2^18.
- x_in=0, y_in=10000 -> mag=16468 +/-8; phase=0x4000_0000 +/-2^18.
- x_in=-10000, y_in=-10000 -> mag=23289 +/-8; phase=0xA000_0000 +/-2^18.
- x_in=-32768, y_in=0 -> mag=53961 +/-8 (no overflow in 18 bits); phase=0x8000_0000 +/-2^18 (mod 2^32).
- x_in=0, y_in=0, then out_ready held low for 10 cycles -> mag=0, phase=0; outputs stable and in_ready=0 throughout; extra in_valid pulses ignored; in_ready=1 the cycle after the out_ready handshake.
- rst pulsed 5 cycles after an accept -> out_valid=0, mag=0, phase=0 immediately; no result is ever emitted for that input; the next accept yields a correct result.
